// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared constants for the interrupt controller
package irq_ctrl_pkg;
  localparam int AW = 10;
  localparam int NIRQ = 4;
  localparam logic [AW-1:0] VEC_BASE = 10'h3F0;
  localparam logic [2:0] LVL_NONE = 3'd4;
  localparam int CTX_W = AW + 3;
  localparam int STACK_DEPTH = 4;
endpackage

// File: rtl/irq_ctrl_ctx_stack.sv
// rtl/irq_ctrl_ctx_stack.sv - 4-entry LIFO of saved {return pc, level} contexts
module ctx_stack
  import irq_ctrl_pkg::*;
#(
  parameter int W = CTX_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic [2:0]   level
);
  logic [W-1:0] mem [STACK_DEPTH];
  logic [2:0]   ptr;
  logic         can_push;

  assign can_push = push && (ptr != 3'(STACK_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 3'd0;
    end else if (can_push) begin
      ptr <= ptr + 3'd1;
    end else if (pop && ptr != 3'd0) begin
      ptr <= ptr - 3'd1;
    end
  end

  // Entries are only reachable below ptr, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (can_push) begin
      mem[ptr[1:0]] <= push_data;
    end
  end

  assign top_data = mem[2'(ptr - 3'd1)];
  assign level    = ptr;
endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - edge-triggered nested priority interrupt controller
module irq_ctrl #(
  parameter int AW = irq_ctrl_pkg::AW,
  parameter int NIRQ = irq_ctrl_pkg::NIRQ,
  parameter logic [AW-1:0] VEC_BASE = irq_ctrl_pkg::VEC_BASE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            irq_en,
  input  logic [AW-1:0]   pc_next,
  input  logic            reti,
  output logic            irq_take,
  output logic [AW-1:0]   vector,
  output logic            ret_valid,
  output logic [AW-1:0]   ret_addr,
  output logic            in_isr,
  output logic [NIRQ-1:0] irq_ack,
  output logic            err_underflow
);
  localparam int CTX_W = AW + 3;

  logic [NIRQ-1:0]  irq_q, pending, rise, eligible, win_mask;
  logic             armed, take, do_pop;
  logic [2:0]       cur_lvl, win_lvl, depth;
  logic [CTX_W-1:0] top_ctx;

  // irq_q must hold a real sample before edges count, so a line held high
  // across reset release is not mistaken for a new request.
  assign rise   = armed ? (irq & ~irq_q) : '0;
  assign do_pop = reti && (depth != 3'd0);

  always_comb begin
    eligible = '0;
    win_mask = '0;
    win_lvl  = irq_ctrl_pkg::LVL_NONE;
    take     = 1'b0;
    for (int i = 0; i < NIRQ; i++) begin
      eligible[i] = pending[i] && irq_en && !reti && (3'(i) < cur_lvl) &&
                    (depth != 3'(irq_ctrl_pkg::STACK_DEPTH));
    end
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_mask    = '0;
        win_mask[i] = 1'b1;
        win_lvl     = 3'(i);
        take        = 1'b1;
      end
    end
  end

  ctx_stack #(.W(CTX_W)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (take),
    .pop       (do_pop),
    .push_data ({pc_next, cur_lvl}),
    .top_data  (top_ctx),
    .level     (depth)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q         <= '0;
      armed         <= 1'b0;
      pending       <= '0;
      cur_lvl       <= irq_ctrl_pkg::LVL_NONE;
      irq_take      <= 1'b0;
      irq_ack       <= '0;
      vector        <= '0;
      ret_valid     <= 1'b0;
      ret_addr      <= '0;
      in_isr        <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      irq_q     <= irq;
      armed     <= 1'b1;
      pending   <= (pending & ~win_mask) | rise;
      irq_take  <= take;
      irq_ack   <= win_mask;
      ret_valid <= do_pop;
      if (take) begin
        cur_lvl <= win_lvl;
        vector  <= VEC_BASE + AW'({win_lvl, 2'b00});
        in_isr  <= 1'b1;
      end else if (do_pop) begin
        cur_lvl  <= top_ctx[2:0];
        ret_addr <= top_ctx[CTX_W-1:3];
        in_isr   <= (depth != 3'd1);
      end
      if (reti && depth == 3'd0) begin
        err_underflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard bench for irq_ctrl against a behavioural model
module tb_irq_ctrl;
  localparam int K_TAKE = 1, K_RET = 2, K_UF = 3;
  localparam logic [9:0] VB = 10'h3F0;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       irq_en;
  logic [9:0] pc_next;
  logic       reti;
  logic       irq_take, ret_valid, in_isr, err_underflow;
  logic [9:0] vector, ret_addr;
  logic [3:0] irq_ack;

  always #5 clk = ~clk;

  irq_ctrl dut (
    .clk(clk), .reset(reset), .irq(irq), .irq_en(irq_en), .pc_next(pc_next),
    .reti(reti), .irq_take(irq_take), .vector(vector), .ret_valid(ret_valid),
    .ret_addr(ret_addr), .in_isr(in_isr), .irq_ack(irq_ack),
    .err_underflow(err_underflow)
  );

  typedef struct { int kind; logic [9:0] addr; logic [3:0] ack; bit isr; } ev_t;
  typedef struct { logic [9:0] pc; int lvl; } ctx_t;

  ev_t  exp_q[$];
  ctx_t m_stk[$];
  bit [3:0]   m_pend, m_prev;
  bit         m_armed, m_err;
  int         m_lvl;
  logic [9:0] m_vec, m_ret;
  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_stk.delete();
    m_pend = 0; m_prev = 0; m_armed = 0; m_err = 0;
    m_lvl = 4; m_vec = '0; m_ret = '0;
  endtask

  // Effect of one rising clock edge under the given inputs.
  task automatic model_edge(logic [3:0] iv, logic en, logic [9:0] pc, logic r);
    bit [3:0] rise;
    int win;
    ctx_t c;
    ev_t e;
    rise = m_armed ? (iv & ~m_prev) : 4'b0;
    win = -1;
    if (r) begin
      if (m_stk.size() > 0) begin
        c = m_stk.pop_back();
        m_lvl = c.lvl;
        m_ret = c.pc;
        e = '{K_RET, c.pc, 4'b0, m_stk.size() > 0};
        exp_q.push_back(e);
      end else if (!m_err) begin
        m_err = 1;
        e = '{K_UF, 10'h0, 4'b0, 1'b0};
        exp_q.push_back(e);
      end
    end else if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (win < 0 && m_pend[i] && i < m_lvl) win = i;
      end
      if (win >= 0) begin
        c = '{pc, m_lvl};
        m_stk.push_back(c);
        m_lvl = win;
        m_pend[win] = 1'b0;
        m_vec = VB + 10'(4 * win);
        e = '{K_TAKE, m_vec, 4'(1 << win), 1'b1};
        exp_q.push_back(e);
      end
    end
    m_pend = m_pend | rise;
    m_prev = iv;
    m_armed = 1;
  endtask

  task automatic step(logic [3:0] iv, logic en, logic [9:0] pc, logic r);
    @(negedge clk);
    irq = iv; irq_en = en; pc_next = pc; reti = r;
    model_edge(iv, en, pc, r);
  endtask

  task automatic idle(int n, logic [9:0] pc);
    for (int k = 0; k < n; k++) step(4'b0, 1'b1, pc, 1'b0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_irq_take"}, irq_take, 0);
    check({tag, "_ret_valid"}, ret_valid, 0);
    check({tag, "_vector"}, vector, 0);
    check({tag, "_ret_addr"}, ret_addr, 0);
    check({tag, "_irq_ack"}, irq_ack, 0);
    check({tag, "_in_isr"}, in_isr, 0);
    check({tag, "_err"}, err_underflow, 0);
  endtask

  task automatic do_reset(logic [3:0] held_irq);
    @(negedge clk);
    #1 reset = 1'b1;
    reti = 1'b0;
    irq = held_irq;
    #1 check("reset_queue_empty", exp_q.size(), 0);
    model_reset();
    check_reset_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    model_edge(irq, irq_en, pc_next, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  logic dut_prev_err = 1'b0;
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (reset) begin
      dut_prev_err = 1'b0;
    end else begin
      check("strobe_exclusive", {irq_take, ret_valid} == 2'b11, 0);
      if (irq_take || ret_valid || (err_underflow && !dut_prev_err)) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_event take=%0b ret=%0b err=%0b required=none",
                   irq_take, ret_valid, err_underflow);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {irq_take, ret_valid, err_underflow && !dut_prev_err},
                e.kind == K_TAKE ? 3'b100 : e.kind == K_RET ? 3'b010 : 3'b001);
          if (e.kind == K_TAKE) begin
            check("take_vector", vector, e.addr);
            check("take_ack", irq_ack, e.ack);
            check("take_in_isr", in_isr, e.isr);
          end else if (e.kind == K_RET) begin
            check("ret_addr", ret_addr, e.addr);
            check("ret_in_isr", in_isr, e.isr);
          end
        end
      end
      if (!irq_take) check("vector_hold", vector, m_vec);
      if (!ret_valid) check("ret_addr_hold", ret_addr, m_ret);
      if (!irq_take) check("ack_idle", irq_ack, 0);
      check("in_isr_level", in_isr, m_stk.size() != 0);
      check("err_sticky", err_underflow, m_err);
      dut_prev_err = err_underflow;
    end
  end

  initial begin
    reset = 1'b1; irq = 4'b0; irq_en = 1'b1; pc_next = 10'h0; reti = 1'b0;
    model_reset();
    #1 check_reset_outputs("power_on");
    @(negedge clk);
    reset = 1'b0;
    model_edge(irq, irq_en, pc_next, 1'b0);

    // basic take and return
    step(4'b0100, 1, 10'h025, 0);
    idle(3, 10'h025);
    step(4'b0000, 1, 10'h000, 1);
    idle(2, 10'h030);

    // simultaneous requests, then tail to line 3
    step(4'b1010, 1, 10'h040, 0);
    idle(3, 10'h041);
    step(4'b0000, 1, 10'h000, 1);
    idle(3, 10'h042);
    step(4'b0000, 1, 10'h000, 1);
    idle(2, 10'h043);

    // nesting with a lower-priority line left pending
    step(4'b0100, 1, 10'h050, 0);
    idle(2, 10'h051);
    step(4'b0001, 1, 10'h3F9, 0);
    idle(2, 10'h3F9);
    step(4'b1000, 1, 10'h060, 0);
    idle(2, 10'h061);
    step(4'b0000, 1, 10'h000, 1);
    idle(2, 10'h062);
    step(4'b0000, 1, 10'h000, 1);
    idle(3, 10'h063);
    step(4'b0000, 1, 10'h000, 1);
    idle(2, 10'h064);

    // underflow, then reti colliding with an eligible take
    step(4'b0000, 1, 10'h000, 1);
    idle(1, 10'h070);
    step(4'b0100, 1, 10'h071, 0);
    idle(2, 10'h072);
    step(4'b0001, 1, 10'h073, 0);
    step(4'b0000, 1, 10'h074, 1);
    idle(3, 10'h075);
    step(4'b0000, 1, 10'h000, 1);
    idle(2, 10'h076);

    // enable gating
    step(4'b0010, 0, 10'h080, 0);
    for (int k = 0; k < 3; k++) step(4'b0000, 0, 10'h081, 0);
    idle(2, 10'h082);
    step(4'b0000, 1, 10'h000, 1);
    idle(2, 10'h083);

    // reset while two contexts are stacked
    step(4'b0100, 1, 10'h090, 0);
    idle(2, 10'h091);
    step(4'b0001, 1, 10'h092, 0);
    idle(2, 10'h093);
    do_reset(4'b0000);
    step(4'b0000, 1, 10'h000, 1);
    idle(2, 10'h094);
    step(4'b1000, 1, 10'h095, 0);
    idle(2, 10'h096);
    step(4'b0000, 1, 10'h000, 1);
    idle(2, 10'h097);

    // line held high across reset release must not fire
    do_reset(4'b1000);
    for (int k = 0; k < 4; k++) step(4'b1000, 1, 10'h0A0, 0);
    idle(2, 10'h0A1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [3:0] iv;
      logic en, r;
      for (int b = 0; b < 4; b++) iv[b] = ($urandom_range(0, 6) == 0);
      en = ($urandom_range(0, 7) != 0);
      r = (m_stk.size() > 0 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 60) == 0);
      step(iv, en, 10'($urandom), r);
      if (n == 300) do_reset(4'($urandom));
    end
    idle(4, 10'h0B0);
    for (int k = 0; k < 5; k++) step(4'b0000, 1, 10'h0B1, m_stk.size() > 0);
    idle(4, 10'h0B2);
    @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
